// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions used by the writeback stage.
//   XLEN          : integer datapath width
//   WB_SEL_*      : result-source select codes from the MEM stage
//   LOAD_F3_*     : load funct3 encodings
//   wb_state_t    : writeback FSM state encoding
//   is_load()     : true when the select code names the load path
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_CSR  = 2'b11;

  localparam logic [2:0] LOAD_F3_LB  = 3'b000;
  localparam logic [2:0] LOAD_F3_LH  = 3'b001;
  localparam logic [2:0] LOAD_F3_LW  = 3'b010;
  localparam logic [2:0] LOAD_F3_LBU = 3'b100;
  localparam logic [2:0] LOAD_F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'b00,
    WB_WAIT_LOAD = 2'b01,
    WB_COMMIT    = 2'b10
  } wb_state_t;

  function automatic logic is_load(input logic [1:0] wb_sel);
    return (wb_sel == WB_SEL_LOAD);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner.
//   f3         in  : load funct3
//   addr_lsb   in  : effective address bits [1:0]
//   rdata      in  : word-aligned data-memory read word
//   data       out : selected, sign/zero-extended load result
//   misaligned out : access is misaligned or funct3 is not a valid load
module load_align #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic [2:0]      f3,
  input  logic [1:0]      addr_lsb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  import rv32_pkg::*;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for byte and halfword accesses
  always_comb begin
    byte_s = rdata[7:0];
    case (addr_lsb)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lsb[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension and misalignment decode; unused funct3 codes count as misaligned
  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (f3)
      LOAD_F3_LB: begin
        data = {{(XLEN-8){byte_s[7]}}, byte_s};
      end
      LOAD_F3_LBU: begin
        data = {{(XLEN-8){1'b0}}, byte_s};
      end
      LOAD_F3_LH: begin
        data       = {{(XLEN-16){half_s[15]}}, half_s};
        misaligned = addr_lsb[0];
      end
      LOAD_F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_s};
        misaligned = addr_lsb[0];
      end
      LOAD_F3_LW: begin
        data       = rdata;
        misaligned = (addr_lsb != 2'b00);
      end
      default: begin
        data       = rdata;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// RV32I writeback stage: selects the retiring result, waits for load data,
// and drives a registered register-file write port.
//   clk_in / rst_in (async, active-low)
//   valid_in / ready_out          : MEM -> WB handshake
//   rd_addr_in, rd_wr_req_in,
//   wb_sel_in, load_f3_in         : instruction control
//   alu_result_in, pc_plus4_in,
//   csr_rdata_in                  : candidate results (alu_result_in is also the load address)
//   dmem_rdata_in, dmem_ack_in    : data-memory response
//   rd_addr_out, rd_out, wr_en_out: register-file write port
//   retire_out, misalign_out,
//   timeout_err_out               : single-cycle status pulses
module writeback_unit #(
  parameter int XLEN         = rv32_pkg::XLEN,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [4:0]      rd_addr_in,
  input  logic            rd_wr_req_in,
  input  logic [1:0]      wb_sel_in,
  input  logic [2:0]      load_f3_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [XLEN-1:0] csr_rdata_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  input  logic            dmem_ack_in,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] rd_out,
  output logic            wr_en_out,
  output logic            retire_out,
  output logic            misalign_out,
  output logic            timeout_err_out
);
  import rv32_pkg::*;

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
  // Value of the counter on the final permitted WAIT_LOAD cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_t         state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [2:0]        ld_f3_r, ld_f3_next_s;
  logic [1:0]        ld_lsb_r, ld_lsb_next_s;
  logic [4:0]        ld_rd_r, ld_rd_next_s;
  logic              ld_req_r, ld_req_next_s;

  logic              ready_r, ready_next_s;
  logic [4:0]        rd_addr_r, rd_addr_next_s;
  logic [XLEN-1:0]   rd_data_r, rd_data_next_s;
  logic              wr_en_r, wr_en_next_s;
  logic              retire_r, retire_next_s;
  logic              misalign_r, misalign_next_s;
  logic              timeout_r, timeout_next_s;

  logic              accept_s;
  logic [XLEN-1:0]   result_s;
  logic [2:0]        al_f3_s;
  logic [1:0]        al_lsb_s;
  logic [XLEN-1:0]   al_data_s;
  logic              al_mis_s;

  // Single aligner: captured load fields while waiting, live inputs otherwise
  assign al_f3_s  = (state_r == WB_WAIT_LOAD) ? ld_f3_r  : load_f3_in;
  assign al_lsb_s = (state_r == WB_WAIT_LOAD) ? ld_lsb_r : alu_result_in[1:0];

  load_align #(.XLEN(XLEN)) u_load_align (
    .f3         (al_f3_s),
    .addr_lsb   (al_lsb_s),
    .rdata      (dmem_rdata_in),
    .data       (al_data_s),
    .misaligned (al_mis_s)
  );

  assign accept_s = valid_in && (state_r != WB_WAIT_LOAD);

  // Non-load result source select
  always_comb begin
    result_s = alu_result_in;
    case (wb_sel_in)
      WB_SEL_ALU: result_s = alu_result_in;
      WB_SEL_PC4: result_s = pc_plus4_in;
      WB_SEL_CSR: result_s = csr_rdata_in;
      default:    result_s = alu_result_in;
    endcase
  end

  // Next-state, timeout counter and next output values
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = {CNT_W{1'b0}};
    ld_f3_next_s    = ld_f3_r;
    ld_lsb_next_s   = ld_lsb_r;
    ld_rd_next_s    = ld_rd_r;
    ld_req_next_s   = ld_req_r;
    rd_addr_next_s  = rd_addr_r;
    rd_data_next_s  = rd_data_r;
    wr_en_next_s    = 1'b0;
    retire_next_s   = 1'b0;
    misalign_next_s = 1'b0;
    timeout_next_s  = 1'b0;
    case (state_r)
      WB_IDLE, WB_COMMIT: begin
        if (accept_s) begin
          if (is_load(wb_sel_in)) begin
            if (al_mis_s) begin
              // Retire immediately with a flag; memory is never consulted
              state_next_s    = WB_COMMIT;
              rd_addr_next_s  = rd_addr_in;
              retire_next_s   = 1'b1;
              misalign_next_s = 1'b1;
            end else begin
              state_next_s  = WB_WAIT_LOAD;
              ld_f3_next_s  = load_f3_in;
              ld_lsb_next_s = alu_result_in[1:0];
              ld_rd_next_s  = rd_addr_in;
              ld_req_next_s = rd_wr_req_in;
            end
          end else begin
            state_next_s   = WB_COMMIT;
            rd_addr_next_s = rd_addr_in;
            rd_data_next_s = result_s;
            wr_en_next_s   = rd_wr_req_in && (rd_addr_in != 5'd0);
            retire_next_s  = 1'b1;
          end
        end else begin
          state_next_s = WB_IDLE;
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_ack_in) begin
          state_next_s   = WB_COMMIT;
          rd_addr_next_s = ld_rd_r;
          rd_data_next_s = al_data_s;
          wr_en_next_s   = ld_req_r && (ld_rd_r != 5'd0);
          retire_next_s  = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s   = WB_IDLE;
          timeout_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s = WB_IDLE;
      end
    endcase
    ready_next_s = (state_next_s != WB_WAIT_LOAD);
  end

  // State, captured load fields and registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r    <= WB_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      ld_f3_r    <= 3'b000;
      ld_lsb_r   <= 2'b00;
      ld_rd_r    <= 5'd0;
      ld_req_r   <= 1'b0;
      ready_r    <= 1'b1;
      rd_addr_r  <= 5'd0;
      rd_data_r  <= {XLEN{1'b0}};
      wr_en_r    <= 1'b0;
      retire_r   <= 1'b0;
      misalign_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      ld_f3_r    <= ld_f3_next_s;
      ld_lsb_r   <= ld_lsb_next_s;
      ld_rd_r    <= ld_rd_next_s;
      ld_req_r   <= ld_req_next_s;
      ready_r    <= ready_next_s;
      rd_addr_r  <= rd_addr_next_s;
      rd_data_r  <= rd_data_next_s;
      wr_en_r    <= wr_en_next_s;
      retire_r   <= retire_next_s;
      misalign_r <= misalign_next_s;
      timeout_r  <= timeout_next_s;
    end
  end

  assign ready_out       = ready_r;
  assign rd_addr_out     = rd_addr_r;
  assign rd_out          = rd_data_r;
  assign wr_en_out       = wr_en_r;
  assign retire_out      = retire_r;
  assign misalign_out    = misalign_r;
  assign timeout_err_out = timeout_r;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a retire scoreboard.
module tb_writeback_unit;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  rd_addr_in;
  logic        rd_wr_req_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  load_f3_in;
  logic [31:0] alu_result_in;
  logic [31:0] pc_plus4_in;
  logic [31:0] csr_rdata_in;
  logic [31:0] dmem_rdata_in;
  logic        dmem_ack_in;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic        wr_en_out;
  logic        retire_out;
  logic        misalign_out;
  logic        timeout_err_out;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  writeback_unit dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .rd_addr_in      (rd_addr_in),
    .rd_wr_req_in    (rd_wr_req_in),
    .wb_sel_in       (wb_sel_in),
    .load_f3_in      (load_f3_in),
    .alu_result_in   (alu_result_in),
    .pc_plus4_in     (pc_plus4_in),
    .csr_rdata_in    (csr_rdata_in),
    .dmem_rdata_in   (dmem_rdata_in),
    .dmem_ack_in     (dmem_ack_in),
    .rd_addr_out     (rd_addr_out),
    .rd_out          (rd_out),
    .wr_en_out       (wr_en_out),
    .retire_out      (retire_out),
    .misalign_out    (misalign_out),
    .timeout_err_out (timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic wr, input logic [4:0] a, input logic [31:0] d,
                              input logic mis);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d; e.mis = mis;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic req,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] csr);
    valid_in = 1'b1; wb_sel_in = sel; rd_addr_in = rd; rd_wr_req_in = req;
    load_f3_in = f3; alu_result_in = alu; pc_plus4_in = pc; csr_rdata_in = csr;
  endtask

  // Accepts an aligned load, acks after 'gap' idle wait cycles, checks the write
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] word, input int gap,
                         input logic [31:0] exp_d);
    issue(2'b01, rd, 1'b1, f3, addr, 32'h0, 32'h0);
    tick();
    valid_in = 1'b0;
    chk({tag, "_ready_low"}, {31'd0, ready_out}, 32'd0);
    repeat (gap) tick();
    dmem_ack_in = 1'b1; dmem_rdata_in = word;
    sb.push_back(mk(1'b1, rd, exp_d, 1'b0));
    tick();
    dmem_ack_in = 1'b0; dmem_rdata_in = 32'hDEAD_BEEF;
    chk({tag, "_wr_en"}, {31'd0, wr_en_out}, 32'd1);
    chk({tag, "_data"}, rd_out, exp_d);
  endtask

  // Scoreboard: every retire pops one expected instruction
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in === 1'b1 && retire_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_retire", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_wr_en", {31'd0, wr_en_out}, {31'd0, e.wr});
        chk("sb_misalign", {31'd0, misalign_out}, {31'd0, e.mis});
        if (e.wr) begin
          chk("sb_rd_addr", {27'd0, rd_addr_out}, {27'd0, e.addr});
          chk("sb_rd_data", rd_out, e.data);
        end
      end
    end
    if (rst_in === 1'b1 && wr_en_out === 1'b1 && retire_out !== 1'b1) begin
      chk("wr_without_retire", {31'd0, retire_out}, 32'd1);
    end
  end

  initial begin
    int n;
    rst_in = 1'b0; valid_in = 1'b0; rd_addr_in = 5'd0; rd_wr_req_in = 1'b0;
    wb_sel_in = 2'b00; load_f3_in = 3'b000; alu_result_in = 32'h0; pc_plus4_in = 32'h0;
    csr_rdata_in = 32'h0; dmem_rdata_in = 32'h0; dmem_ack_in = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_outs", {25'd0, wr_en_out, retire_out, misalign_out, timeout_err_out, rd_addr_out == 5'd0
                     ? 1'b0 : 1'b1, rd_out == 32'd0 ? 1'b0 : 1'b1, 1'b0}, 32'd0);
    rst_in = 1'b1;
    tick();

    // ALU op: one-cycle latency
    issue(2'b00, 5'd5, 1'b1, 3'b000, 32'h1234, 32'h0, 32'h0);
    sb.push_back(mk(1'b1, 5'd5, 32'h1234, 1'b0));
    tick();
    valid_in = 1'b0;
    chk("alu_wr_en", {31'd0, wr_en_out}, 32'd1);
    chk("alu_retire", {31'd0, retire_out}, 32'd1);
    chk("alu_rd_addr", {27'd0, rd_addr_out}, 32'd5);
    chk("alu_rd_out", rd_out, 32'h1234);
    tick();
    chk("idle_wr_en", {31'd0, wr_en_out}, 32'd0);
    chk("idle_hold", rd_out, 32'h1234);

    // rd = x0 retires without a write
    issue(2'b00, 5'd0, 1'b1, 3'b000, 32'h5555, 32'h0, 32'h0);
    sb.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0));
    tick();
    valid_in = 1'b0;
    chk("x0_retire", {31'd0, retire_out}, 32'd1);
    chk("x0_wr_en", {31'd0, wr_en_out}, 32'd0);
    tick();

    // PC+4 and CSR sources
    issue(2'b10, 5'd1, 1'b1, 3'b000, 32'h1111, 32'h0000_0104, 32'h2222);
    sb.push_back(mk(1'b1, 5'd1, 32'h0000_0104, 1'b0));
    tick();
    issue(2'b11, 5'd2, 1'b1, 3'b000, 32'h1111, 32'h0000_0104, 32'h0000_CAFE);
    sb.push_back(mk(1'b1, 5'd2, 32'h0000_CAFE, 1'b0));
    tick();
    valid_in = 1'b0;
    chk("csr_rd_out", rd_out, 32'h0000_CAFE);
    tick();

    // Loads: alignment and extension
    do_load("lb", 3'b000, 32'h0000_1003, 5'd7, 32'h80FF_FF7F, 2, 32'hFFFF_FF80);
    do_load("lhu", 3'b101, 32'h0000_2002, 5'd8, 32'hBEEF_0000, 0, 32'h0000_BEEF);
    do_load("lh", 3'b001, 32'h0000_2000, 5'd9, 32'h1234_8001, 1, 32'hFFFF_8001);
    do_load("lbu", 3'b100, 32'h0000_2001, 5'd10, 32'h0000_8000, 0, 32'h0000_0080);
    do_load("lw", 3'b010, 32'h0000_3000, 5'd11, 32'h1234_5678, 4, 32'h1234_5678);
    tick();

    // Misaligned loads retire with a flag and no wait
    issue(2'b01, 5'd12, 1'b1, 3'b010, 32'h0000_4001, 32'h0, 32'h0);
    sb.push_back(mk(1'b0, 5'd12, 32'h0, 1'b1));
    tick();
    valid_in = 1'b0;
    chk("mis_lw_flag", {31'd0, misalign_out}, 32'd1);
    chk("mis_lw_wr_en", {31'd0, wr_en_out}, 32'd0);
    chk("mis_lw_ready", {31'd0, ready_out}, 32'd1);
    issue(2'b01, 5'd13, 1'b1, 3'b011, 32'h0000_4000, 32'h0, 32'h0);
    sb.push_back(mk(1'b0, 5'd13, 32'h0, 1'b1));
    tick();
    valid_in = 1'b0;
    chk("mis_f3_011_flag", {31'd0, misalign_out}, 32'd1);
    tick();

    // Timeout: no ack for 255 cycles
    issue(2'b01, 5'd14, 1'b1, 3'b010, 32'h0000_5000, 32'h0, 32'h0);
    tick();
    valid_in = 1'b0;
    n = 0;
    while (n < 300 && timeout_err_out !== 1'b1) begin
      if (n == 100) chk("to_ready_low", {31'd0, ready_out}, 32'd0);
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_ready", {31'd0, ready_out}, 32'd1);
    chk("to_no_retire", {30'd0, retire_out, wr_en_out}, 32'd0);
    tick();
    chk("to_pulse_end", {31'd0, timeout_err_out}, 32'd0);
    dmem_ack_in = 1'b1; dmem_rdata_in = 32'hFFFF_FFFF;
    tick();
    dmem_ack_in = 1'b0;
    chk("late_ack_ignored", {30'd0, retire_out, wr_en_out}, 32'd0);
    tick();

    // Back-to-back ALU ops, valid held
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 5'(16 + i), 1'b1, 3'b000, 32'hA000_0000 + 32'(i), 32'h0, 32'h0);
      sb.push_back(mk(1'b1, 5'(16 + i), 32'hA000_0000 + 32'(i), 1'b0));
      tick();
      chk("b2b_wr_en", {31'd0, wr_en_out}, 32'd1);
      chk("b2b_rd_out", rd_out, 32'hA000_0000 + 32'(i));
    end
    valid_in = 1'b0;
    tick();
    chk("b2b_end", {31'd0, wr_en_out}, 32'd0);

    // Reset during WAIT_LOAD
    issue(2'b01, 5'd20, 1'b1, 3'b000, 32'h0000_6000, 32'h0, 32'h0);
    tick();
    valid_in = 1'b0;
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    chk("rst_mid_outs", {27'd0, wr_en_out, retire_out, misalign_out, timeout_err_out,
                         rd_out == 32'd0 ? 1'b0 : 1'b1}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready_out}, 32'd1);
    tick();
    rst_in = 1'b1;
    dmem_ack_in = 1'b1; dmem_rdata_in = 32'h0000_0077;
    tick();
    dmem_ack_in = 1'b0;
    chk("rst_no_write", {30'd0, wr_en_out, retire_out}, 32'd0);
    tick();
    chk("rst_no_write2", {30'd0, wr_en_out, retire_out}, 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
